// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the pipeline data-memory responder.
//   - FSM state encoding (IDLE, WAIT, RESP)
//   - data width, byte-enable width, wait-counter width
package dmem_pkg;

   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_ram.sv
// dmem_ram: word array of 2^ADDR_WIDTH x 32 bits with a synchronous read
// port and a byte-enabled write port. Contents are never reset.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (read-data register only)
//   re_i     read strobe; rdata_o shows the addressed word after the edge
//   we_i     write strobe; only bytes with be_i set are written
//   addr_i   word index
//   wdata_i  write data
//   be_i     byte enables, bit n covers bits [8n+7:8n]
//   rdata_o  registered read data, 0 on cycles following a non-read edge
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  re_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [BE_W-1:0]       be_i,
   output logic [DATA_W-1:0]     rdata_o
);

   logic [DATA_W-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Cleared whenever no read happens, so stores and rejected requests
   // naturally return zero data in the response cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdata_q <= '0;
      else         rdata_q <= re_i ? mem[addr_i] : '0;
   end

   assign rdata_o = rdata_q;

endmodule : dmem_ram

// File: rtl/pipeline_dmem_responder.sv
// pipeline_dmem_responder: MEM-stage load/store responder. Accepts one word
// request at a time, waits LATENCY cycles, accesses the array and returns a
// one-cycle response pulse.
// Optional feature macro: DMEM_ACCESS_CHECK_EN (misaligned / out-of-range
// requests are rejected with rsp_error=1 and no array write).
// Handshake: a request is accepted on a rising edge where req_valid=1 and
// req_ready=1; req_ready is high only in IDLE; rsp_valid is a single-cycle
// pulse with no back-pressure.
// Ports:
//   clock, reset (async active-low)
//   req_valid, req_ready, req_write, req_addr, req_wdata, req_be  request side
//   rsp_valid, rsp_rdata, rsp_error                               response side
module pipeline_dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error
);

   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

   dmem_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              rsp_err_q, rsp_err_d;

   logic              enter_resp;
   logic              acc_wr;
   logic [31:0]       acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [BE_W-1:0]   acc_be;
   logic              acc_err;

   // With zero latency the array is accessed on the accept edge itself, so
   // the live request is used instead of the (not yet loaded) latch.
   always_comb begin
      if (state_q == ST_IDLE) begin
         acc_wr    = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end else begin
         acc_wr    = wr_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
   end

`ifdef DMEM_ACCESS_CHECK_EN
   assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != '0);
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{acc_addr[31:ADDR_WIDTH+2], acc_addr[1:0]};
   assign acc_err          = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      enter_resp = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               if (LATENCY == 0) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      rsp_err_d = enter_resp && acc_err;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   dmem_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk_i   (clock),
      .rst_ni  (reset),
      .re_i    (enter_resp && !acc_wr && !acc_err),
      .we_i    (enter_resp &&  acc_wr && !acc_err),
      .addr_i  (acc_addr[ADDR_WIDTH+1:2]),
      .wdata_i (acc_wdata),
      .be_i    (acc_be),
      .rdata_o (rsp_rdata)
   );

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_error = rsp_err_q;

endmodule : pipeline_dmem_responder

// File: tb/tb_pipeline_dmem_responder.sv
// Bench for pipeline_dmem_responder: a LATENCY=2 instance (dut) and a
// LATENCY=0 instance (dut0) sharing clock, reset and request payload.
module tb_pipeline_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_valid0 = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready, req_ready0;
   logic        rsp_valid, rsp_valid0;
   logic [31:0] rsp_rdata, rsp_rdata0;
   logic        rsp_error, rsp_error0;

   int n_vec = 0;
   int n_err = 0;
   logic [32:0] exp_q[$];
   logic [32:0] exp0_q[$];
   logic [31:0] exp_w1;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   pipeline_dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
      .clock(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
   );

   pipeline_dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
      .clock(clk), .reset(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: compare every response against the queued expectation
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
         else chk("rsp", {31'd0, rsp_error, rsp_rdata}, {31'd0, exp_q.pop_front()});
      end
      if (rst_n && rsp_valid0) begin
         if (exp0_q.size() == 0) chk("unexpected_rsp0", 64'd1, 64'd0);
         else chk("rsp0", {31'd0, rsp_error0, rsp_rdata0}, {31'd0, exp0_q.pop_front()});
      end
   end

   // driver: called at a negedge with the target instance idle
   task automatic issue(input bit which, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      if (which) req_valid0 = 1'b1; else req_valid = 1'b1;
      chk("ready_before_accept", {63'd0, which ? req_ready0 : req_ready}, 64'd1);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_valid0 = 1'b0;
   endtask

   // counts negedges after the accept edge until the response pulse, then
   // checks ready comes back on the following negedge
   task automatic wait_rsp(input bit which, input int exp_lat, input string tag);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) chk({tag, "_ready_low"}, {63'd0, which ? req_ready0 : req_ready}, 64'd0);
         if (which ? rsp_valid0 : rsp_valid) seen = 1;
      end
      chk({tag, "_latency"}, seen ? 64'(n) : 64'hFFFF, 64'(exp_lat));
      @(negedge clk);
      chk({tag, "_ready_back"}, {63'd0, which ? req_ready0 : req_ready}, 64'd1);
   endtask

   initial begin
      int last;
      int nacc;
      int widx;
      // reset and preload word[i] = i + 0xAA
      for (int i = 0; i < 16; i++) begin
         dut.u_ram.mem[i]  <= 32'hAA + 32'(i);
         dut0.u_ram.mem[i] <= 32'hAA + 32'(i);
      end
      exp_w1 = 32'hAB;
      repeat (2) @(negedge clk);
      chk("rst_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("rst_error", {63'd0, rsp_error}, 64'd0);
      rst_n = 1'b1;

      // load word 2
      exp_q.push_back({1'b0, 32'h0000_00AC});
      issue(0, 0, 32'h8, 32'h0, 4'hF);
      wait_rsp(0, 3, "load8");

      // partial store then read-back of merged word
      exp_q.push_back({1'b0, 32'h0});
      issue(0, 1, 32'h0, 32'h1234_5678, 4'b0011);
      wait_rsp(0, 3, "store0");
      exp_q.push_back({1'b0, 32'h0000_5678});
      issue(0, 0, 32'h0, 32'h0, 4'hF);
      wait_rsp(0, 3, "load0");

      // store with no byte enables leaves word 4 untouched
      exp_q.push_back({1'b0, 32'h0});
      issue(0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0000);
      wait_rsp(0, 3, "store_be0");
      exp_q.push_back({1'b0, 32'h0000_00AE});
      issue(0, 0, 32'h10, 32'h0, 4'hF);
      wait_rsp(0, 3, "load10");

      // back-to-back loads with req_valid held high: words 5..8
      req_write = 1'b0;
      req_be    = 4'hF;
      widx      = 5;
      req_addr  = 32'(widx) << 2;
      req_valid = 1'b1;
      last = -1;
      nacc = 0;
      for (int c = 0; c < 40 && nacc < 4; c++) begin
         if (req_ready) begin
            if (last >= 0) chk("b2b_gap", 64'(c - last), 64'd4);
            exp_q.push_back({1'b0, 32'hAA + 32'(widx)});
            last = c;
            nacc++;
            @(negedge clk);
            widx++;
            req_addr = 32'(widx) << 2;
            if (nacc == 4) req_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 64'(nacc), 64'd4);
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
      chk("b2b_drained", 64'(exp_q.size()), 64'd0);
      @(negedge clk);

      // misaligned store, then out-of-range load
`ifdef DMEM_ACCESS_CHECK_EN
      exp_q.push_back({1'b1, 32'h0});
`else
      exp_q.push_back({1'b0, 32'h0});
      exp_w1 = 32'h1111_1111;
`endif
      issue(0, 1, 32'h6, 32'h1111_1111, 4'hF);
      wait_rsp(0, 3, "store6");
      exp_q.push_back({1'b0, exp_w1});
      issue(0, 0, 32'h4, 32'h0, 4'hF);
      wait_rsp(0, 3, "load4");
`ifdef DMEM_ACCESS_CHECK_EN
      exp_q.push_back({1'b1, 32'h0});
`else
      exp_q.push_back({1'b0, 32'h0000_5678});
`endif
      issue(0, 0, 32'h1000, 32'h0, 4'hF);
      wait_rsp(0, 3, "load1000");

      // reset during WAIT discards a pending store
      issue(0, 1, 32'h4, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", {63'd0, req_ready}, 64'd1);
      chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("midrst_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("midrst_error", {63'd0, rsp_error}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_no_rsp", 64'(exp_q.size()), 64'd0);
      exp_q.push_back({1'b0, exp_w1});
      issue(0, 0, 32'h4, 32'h0, 4'hF);
      wait_rsp(0, 3, "load4_after_rst");

      // zero-latency instance
      exp0_q.push_back({1'b0, 32'h0000_00AD});
      issue(1, 0, 32'hC, 32'h0, 4'hF);
      wait_rsp(1, 1, "lat0_loadC");

      chk("final_q_empty", 64'(exp_q.size()), 64'd0);
      chk("final_q0_empty", 64'(exp0_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pipeline_dmem_responder
